// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
//   state_t    : arbiter FSM state (IDLE / GRANT)
//   clog2      : ceiling log2 for sizing counters and indices
//   idx2onehot : index to one-hot vector (MAX_REQ bits wide; callers slice)
package fifo_arb_pkg;

  localparam int unsigned MAX_REQ = 32;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

  function automatic logic [MAX_REQ-1:0] idx2onehot(input int unsigned idx);
    return MAX_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//   req    in  NREQ  request vector
//   ptr    in  PW    highest-priority index for this scan
//   any    out 1     some request is set
//   idx    out PW    first set request scanning ptr, ptr+1, ... mod NREQ
//   onehot out NREQ  one-hot form of idx (0 when any=0)
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned PW   = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic            any,
  output logic [PW-1:0]   idx,
  output logic [NREQ-1:0] onehot
);

  logic [PW-1:0]      cand;
  logic [MAX_REQ-1:0] oh_full;

  always_comb begin
    any  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = PW'((32'(ptr) + k) % NREQ);
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

  assign oh_full = idx2onehot(32'(idx));
  assign onehot  = any ? oh_full[NREQ-1:0] : '0;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ producers.
// A grant lasts up to BURST words, until the grantee's req_last, or until
// the grantee has been idle IDLE_MAX cycles. Stalls while full is high.
//   clk, rst   write clock, synchronous active-high reset
//   req_valid  in  NREQ      per-requester word valid
//   req_last   in  NREQ      per-requester last word (qualified by valid)
//   req_data   in  NREQ*MSB  requester i data on [i*MSB +: MSB]
//   req_ready  out NREQ      word accepted when valid & ready
//   full       in  1         FIFO full flag
//   winc       out 1         FIFO write strobe
//   wdata      out MSB       FIFO write data (0 when winc=0)
//   grant      out NREQ      one-hot registered grantee
//   busy       out 1         high in GRANT state
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned MSB      = 8,
  parameter int unsigned BURST    = 4,
  parameter int unsigned IDLE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ-1:0]   req_last,
  input  logic [NREQ*MSB-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  input  logic              full,
  output logic              winc,
  output logic [MSB-1:0]    wdata,
  output logic [NREQ-1:0]   grant,
  output logic              busy
);

  localparam int unsigned PW = clog2(NREQ);
  localparam int unsigned BW = clog2(BURST) + 1;
  localparam int unsigned IW = clog2(IDLE_MAX) + 1;

  state_t          state;
  logic [PW-1:0]   rr_ptr;
  logic [BW-1:0]   burst_cnt;
  logic [IW-1:0]   idle_cnt;

  logic            pick_any;
  logic [PW-1:0]   pick_idx;
  logic [NREQ-1:0] pick_onehot;
  logic [PW-1:0]   ptr_next;

  logic            active;
  logic            g_valid;
  logic            g_last;
  logic [MSB-1:0]  g_data;
  logic            xfer;

  rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req    (req_valid),
    .ptr    (rr_ptr),
    .any    (pick_any),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

  assign ptr_next = (pick_idx == PW'(NREQ - 1)) ? '0 : pick_idx + PW'(1);

  // Grantee selection uses the registered one-hot grant directly as the mux select.
  always_comb begin
    g_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[i]) g_data = req_data[i*MSB +: MSB];
    end
  end

  assign g_valid = |(req_valid & grant);
  assign g_last  = |(req_last & grant);

  // Gating with rst keeps the reset cycle free of writes even though state is still GRANT.
  assign active    = (state == ST_GRANT) && !rst;
  assign xfer      = active && g_valid && !full;
  assign winc      = xfer;
  assign wdata     = xfer ? g_data : '0;
  assign req_ready = (active && !full) ? grant : '0;
  assign busy      = (state == ST_GRANT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      grant     <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
      idle_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            state     <= ST_GRANT;
            grant     <= pick_onehot;
            rr_ptr    <= ptr_next;
            burst_cnt <= '0;
            idle_cnt  <= '0;
          end
        end
        ST_GRANT: begin
          if (xfer) begin
            idle_cnt  <= '0;
            burst_cnt <= (burst_cnt == '1) ? burst_cnt : burst_cnt + BW'(1);
            if (g_last || burst_cnt == BW'(BURST - 1)) begin
              state <= ST_IDLE;
              grant <= '0;
            end
          end else if (!g_valid) begin
            idle_cnt <= (idle_cnt == '1) ? idle_cnt : idle_cnt + IW'(1);
            if (idle_cnt == IW'(IDLE_MAX - 1)) begin
              state <= ST_IDLE;
              grant <= '0;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          grant <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_last;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        full;
  logic        winc;
  logic [7:0]  wdata;
  logic [3:0]  grant;
  logic        busy;

  int checks = 0;
  int errors = 0;

  fifo_wr_arbiter #(.NREQ(4), .MSB(8), .BURST(4), .IDLE_MAX(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_data  (req_data),
    .req_ready (req_ready),
    .full      (full),
    .winc      (winc),
    .wdata     (wdata),
    .grant     (grant),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int unsigned i, input logic [7:0] v);
    req_data[i*8 +: 8] = v;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 4'b1111;
    req_last  = 4'b1111;
    full      = 1'b0;
    req_data  = 32'hA3A2A1A0;

    // T1 reset with all requesters valid
    repeat (3) begin
      tick();
      chk("t1_grant", 32'(grant), 32'h0);
      chk("t1_winc",  32'(winc),  32'h0);
      chk("t1_busy",  32'(busy),  32'h0);
    end
    rst = 1'b0;
    #1;
    chk("t1_idle_winc", 32'(winc), 32'h0);
    tick();

    // T2 round robin of single-word packets
    for (int unsigned k = 0; k < 5; k++) begin
      chk("t2_grant", 32'(grant), 32'(1) << (k % 4));
      chk("t2_ready", 32'(req_ready), 32'(1) << (k % 4));
      chk("t2_winc",  32'(winc), 32'h1);
      chk("t2_wdata", 32'(wdata), 32'hA0 + (k % 4));
      tick();
      chk("t2_gap_grant", 32'(grant), 32'h0);
      chk("t2_gap_winc",  32'(winc),  32'h0);
      chk("t2_gap_busy",  32'(busy),  32'h0);
      if (k == 4) req_valid = 4'b0000;
      tick();
    end

    // T3 burst limit: req0 capped at 4 words, req1 then req0 again
    req_valid = 4'b0011;
    req_last  = 4'b0010;
    set_data(1, 8'hB1);
    do_reset();
    tick();
    for (int unsigned w = 0; w < 4; w++) begin
      set_data(0, 8'(32'h10 + w));
      #1;
      chk("t3_grant0", 32'(grant), 32'h1);
      chk("t3_winc",   32'(winc),  32'h1);
      chk("t3_wdata",  32'(wdata), 32'h10 + w);
      tick();
    end
    chk("t3_release", 32'(grant), 32'h0);
    set_data(0, 8'h14);
    tick();
    chk("t3_grant1", 32'(grant), 32'h2);
    chk("t3_wdata1", 32'(wdata), 32'hB1);
    tick();
    req_valid = 4'b0001;
    req_last  = 4'b0001;
    chk("t3_gap", 32'(grant), 32'h0);
    tick();
    chk("t3_resume_grant", 32'(grant), 32'h1);
    chk("t3_resume_wdata", 32'(wdata), 32'h14);
    tick();
    req_valid = 4'b0000;
    tick();

    // T4 full stall mid-burst on req2
    req_valid = 4'b0100;
    req_last  = 4'b0000;
    set_data(2, 8'h20);
    do_reset();
    tick();
    chk("t4_grant", 32'(grant), 32'h4);
    chk("t4_w0",    32'(wdata), 32'h20);
    tick();
    set_data(2, 8'h21);
    full = 1'b1;
    #1;
    repeat (5) begin
      chk("t4_stall_winc",  32'(winc),      32'h0);
      chk("t4_stall_ready", 32'(req_ready), 32'h0);
      chk("t4_stall_grant", 32'(grant),     32'h4);
      chk("t4_stall_busy",  32'(busy),      32'h1);
      tick();
    end
    full = 1'b0;
    #1;
    chk("t4_w1_winc", 32'(winc),  32'h1);
    chk("t4_w1",      32'(wdata), 32'h21);
    tick();
    set_data(2, 8'h22);
    #1;
    chk("t4_w2", 32'(wdata), 32'h22);
    tick();
    set_data(2, 8'h23);
    #1;
    chk("t4_w3_winc",  32'(winc),  32'h1);
    chk("t4_w3",       32'(wdata), 32'h23);
    chk("t4_w3_grant", 32'(grant), 32'h4);
    tick();
    chk("t4_release", 32'(grant), 32'h0);
    chk("t4_busy",    32'(busy),  32'h0);
    req_valid = 4'b0000;

    // T5 idle revoke of req1, then req3 granted
    req_valid = 4'b0010;
    req_last  = 4'b1000;
    set_data(3, 8'hD3);
    do_reset();
    tick();
    req_valid = 4'b1000;
    for (int unsigned c = 1; c <= 8; c++) begin
      #1;
      chk("t5_hold_grant", 32'(grant),     32'h2);
      chk("t5_hold_winc",  32'(winc),      32'h0);
      chk("t5_hold_ready", 32'(req_ready), 32'h2);
      tick();
    end
    chk("t5_revoked", 32'(grant), 32'h0);
    chk("t5_busy",    32'(busy),  32'h0);
    tick();
    chk("t5_next_grant", 32'(grant), 32'h8);
    chk("t5_next_winc",  32'(winc),  32'h1);
    chk("t5_next_wdata", 32'(wdata), 32'hD3);
    tick();
    req_valid = 4'b0000;

    // T6 reset mid-burst
    req_valid = 4'b0001;
    req_last  = 4'b0000;
    set_data(0, 8'h30);
    do_reset();
    tick();
    #1;
    chk("t6_w0", 32'(wdata), 32'h30);
    tick();
    set_data(0, 8'h31);
    #1;
    chk("t6_w1", 32'(wdata), 32'h31);
    tick();
    set_data(0, 8'h32);
    rst = 1'b1;
    #1;
    chk("t6_rst_winc",  32'(winc),      32'h0);
    chk("t6_rst_ready", 32'(req_ready), 32'h0);
    chk("t6_rst_wdata", 32'(wdata),     32'h0);
    tick();
    chk("t6_grant", 32'(grant), 32'h0);
    chk("t6_busy",  32'(busy),  32'h0);
    chk("t6_winc",  32'(winc),  32'h0);
    rst = 1'b0;
    req_valid = 4'b1001;
    #1;
    chk("t6_idle_winc", 32'(winc), 32'h0);
    tick();
    chk("t6_ptr_reset", 32'(grant), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
